// File: rtl/emu_ram_pkg.sv
// rtl/emu_ram_pkg.sv - shared encodings and data-lane helpers for the emulated RAM
//
// Contents:
//   F3_*            RV32 load/store funct3 encodings accepted on req_rwtyp
//   state_e         handshake FSM states (IDLE / ACCESS / RESP)
//   byte_enable()   4-bit write strobe for a given access size and byte lane
//   align_wdata()   right-aligned store data moved onto its byte lane
//   format_load()   word read from the array -> sign/zero-extended load result

package emu_ram_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Only the store sizes (B/H/W) produce a strobe; anything else writes nothing.
    function automatic logic [3:0] byte_enable(input logic [2:0] rwtyp,
                                               input logic [1:0] lane);
        logic [3:0] be;
        case (rwtyp)
            F3_B:    be = 4'b0001 << lane;
            F3_H:    be = 4'b0011 << lane;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] align_wdata(input logic [31:0] wdata,
                                                input logic [1:0]  lane);
        return wdata << {lane, 3'b000};
    endfunction

    // Bring the addressed byte lane down to bit 0, then truncate and extend.
    function automatic logic [31:0] format_load(input logic [31:0] word,
                                                input logic [2:0]  rwtyp,
                                                input logic [1:0]  lane);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (rwtyp)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    result = shifted;
            F3_BU:   result = {24'h0, shifted[7:0]};
            F3_HU:   result = {16'h0, shifted[15:0]};
            default: result = 32'h0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/emu_ram_array.sv
// rtl/emu_ram_array.sv - 2**DEPTH_LOG2 x 32 synchronous RAM with byte enables
//
// Ports:
//   clk    in   clock; write and read both take effect on the rising edge
//   we     in   write strobe, gated per byte by be
//   be     in   4-bit byte enables
//   addr   in   word address shared by the read and write port
//   wdata  in   lane-aligned write data
//   re     in   read strobe; loads mem[addr] into the output register
//   rdata  out  registered read data, holds until the next re

module emu_ram_array #(
    parameter int DEPTH_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Array contents are never reset; only the bus side is cleared by the parent.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

`ifdef __VERILATOR__
    function int unsigned emu_ram_peek(input int unsigned idx);
        if (idx < 2**DEPTH_LOG2) begin
            return mem[idx[DEPTH_LOG2-1:0]];
        end
        return 0;
    endfunction
`endif

endmodule

// File: rtl/emu_ram_hs.sv
// rtl/emu_ram_hs.sv - valid/ready load/store front end for an emulated RV32 data RAM
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready request handshake; fields sampled on the transfer edge
//   req_we              1 = store, 0 = load
//   req_rwtyp           RV32 funct3 size/sign code
//   req_addr            byte address (BASE_ADDR maps to word 0)
//   req_wdata           right-aligned store data
//   resp_valid/ready    response handshake
//   resp_rdata          formatted load data, 0 for stores and faults
//   resp_err            access faulted and had no memory side effect

module emu_ram_hs
    import emu_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_rwtyp,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    // Size of the mapped window in bytes, one bit wider than the address so
    // the comparison cannot overflow when the window fills the address space.
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(1) << (DEPTH_LOG2 + 2);

    state_e      state_d,      state_q;
    logic [1:0]  lane_d,       lane_q;
    logic [2:0]  rwtyp_d,      rwtyp_q;
    logic        err_d,        err_q;
    logic        we_d,         we_q;
    logic [31:0] resp_rdata_d, resp_rdata_q;
    logic        resp_err_d,   resp_err_q;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  out_of_range;
    logic                  bad_type;
    logic                  bad_store;
    logic                  misaligned;
    logic                  req_err;
    logic                  xfer;

    logic                  ram_we;
    logic                  ram_re;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    // Unsigned subtraction: addresses below the base wrap to huge offsets and fault.
    assign offset       = req_addr - BASE_ADDR;
    assign out_of_range = {1'b0, offset} >= SPAN;

    always_comb begin
        bad_type = 1'b0;
        case (req_rwtyp)
            3'b011, 3'b110, 3'b111: bad_type = 1'b1;
            default:                bad_type = 1'b0;
        endcase
    end

    // BU/HU have no store counterpart.
    assign bad_store  = req_we && (req_rwtyp == F3_BU || req_rwtyp == F3_HU);

    always_comb begin
        misaligned = 1'b0;
        case (req_rwtyp)
            F3_H, F3_HU: misaligned = req_addr[0];
            F3_W:        misaligned = (req_addr[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end

    assign req_err = bad_type || bad_store || misaligned || out_of_range;

    // Gating with rst also blocks a store presented on a reset edge.
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign xfer      = req_valid && req_ready;

    // The array is touched only on the accepting edge, and never for a fault.
    assign ram_we    = xfer &&  req_we && !req_err;
    assign ram_re    = xfer && !req_we && !req_err;
    assign ram_be    = byte_enable(req_rwtyp, req_addr[1:0]);
    assign ram_wdata = align_wdata(req_wdata, req_addr[1:0]);

    emu_ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (offset[DEPTH_LOG2+1:2]),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        rwtyp_d      = rwtyp_q;
        err_d        = err_q;
        we_d         = we_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_ACCESS;
                    lane_d  = req_addr[1:0];
                    rwtyp_d = req_rwtyp;
                    err_d   = req_err;
                    we_d    = req_we;
                end
            end
            ST_ACCESS: begin
                // Read data from the accepting edge is valid here; format and capture it.
                state_d    = ST_RESP;
                resp_err_d = err_q;
                if (err_q || we_q) begin
                    resp_rdata_d = 32'h0;
                end else begin
                    resp_rdata_d = format_load(ram_rdata, rwtyp_q, lane_q);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset drops any in-flight access; its response is simply never produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lane_q       <= 2'b00;
            rwtyp_q      <= 3'b000;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            rwtyp_q      <= rwtyp_d;
            err_q        <= err_d;
            we_q         <= we_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_emu_ram_hs.sv
// tb/tb_emu_ram_hs.sv - directed scoreboard bench for emu_ram_hs

module tb_emu_ram_hs;
    import emu_ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_rwtyp;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    emu_ram_hs dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_rwtyp  (req_rwtyp),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction; hold > 0 stalls the response and keeps a
    // stray store to 0x8000_0020 on the request port while stalled.
    task automatic xact(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold);
        exp_t        e;
        logic [31:0] held_d;
        logic        held_e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_rwtyp = typ;
        req_addr  = addr;
        req_wdata = wdata;
        chk("req_ready_idle", req_ready, 32'd1);
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        req_valid = 1'b0;
        chk("access_resp_valid", resp_valid, 32'd0);
        chk("access_req_ready", req_ready, 32'd0);
        @(negedge clk);
        chk("latency_resp_valid", resp_valid, 32'd1);
        held_d = resp_rdata;
        held_e = resp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_rwtyp = F3_W;
            req_addr  = 32'h8000_0020;
            req_wdata = 32'hA5A5_A5A5;
            @(negedge clk);
            chk("hold_resp_valid", resp_valid, 32'd1);
            chk("hold_rdata", resp_rdata, held_d);
            chk("hold_err", resp_err, {31'd0, held_e});
            chk("hold_req_ready", req_ready, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", resp_err, {31'd0, e.err});
        end
        @(negedge clk);
        resp_ready = 1'b0;
        chk("after_resp_valid", resp_valid, 32'd0);
        chk("after_req_ready", req_ready, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_rwtyp  = F3_W;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", req_ready, 32'd0);
            chk("rst_resp_valid", resp_valid, 32'd0);
            chk("rst_resp_err", resp_err, 32'd0);
            chk("rst_resp_rdata", resp_rdata, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 32'd1);

        xact(1'b1, F3_W,  32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0);
        xact(1'b0, F3_W,  32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
        xact(1'b0, F3_B,  32'h8000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0, 0);
        xact(1'b0, F3_BU, 32'h8000_0013, 32'h0,         32'h0000_00DE, 1'b0, 0);
        xact(1'b0, F3_H,  32'h8000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0, 0);
        xact(1'b0, F3_HU, 32'h8000_0010, 32'h0,         32'h0000_BEEF, 1'b0, 0);

        xact(1'b1, F3_B,  32'h8000_0011, 32'hFFFF_FF55, 32'h0000_0000, 1'b0, 0);
        xact(1'b0, F3_W,  32'h8000_0010, 32'h0,         32'hDEAD_55EF, 1'b0, 0);

        xact(1'b0, F3_W,  32'h8000_0012, 32'h0,         32'h0000_0000, 1'b1, 0);
        xact(1'b1, F3_H,  32'h8000_0011, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 0);
        xact(1'b0, F3_W,  32'h7FFF_FFFC, 32'h0,         32'h0000_0000, 1'b1, 0);
        xact(1'b0, 3'b011, 32'h8000_0010, 32'h0,        32'h0000_0000, 1'b1, 0);
        xact(1'b1, F3_BU, 32'h8000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1, 0);
        xact(1'b0, F3_W,  32'h8004_0000, 32'h0,         32'h0000_0000, 1'b1, 0);
        xact(1'b0, F3_W,  32'h8000_0010, 32'h0,         32'hDEAD_55EF, 1'b0, 0);

        xact(1'b1, F3_H,  32'h8000_0012, 32'h1234_CAFE, 32'h0000_0000, 1'b0, 0);
        xact(1'b0, F3_W,  32'h8000_0010, 32'h0,         32'hCAFE_55EF, 1'b0, 0);
        xact(1'b0, F3_H,  32'h8000_0012, 32'h0,         32'hFFFF_CAFE, 1'b0, 0);
        xact(1'b0, F3_B,  32'h8000_0010, 32'h0,         32'hFFFF_FFEF, 1'b0, 0);
        xact(1'b0, F3_HU, 32'h8000_0012, 32'h0,         32'h0000_CAFE, 1'b0, 0);
        xact(1'b0, F3_BU, 32'h8000_0011, 32'h0,         32'h0000_0055, 1'b0, 0);

        xact(1'b1, F3_W,  32'h8003_FFFC, 32'h0123_4567, 32'h0000_0000, 1'b0, 0);
        xact(1'b0, F3_W,  32'h8003_FFFC, 32'h0,         32'h0123_4567, 1'b0, 0);
        xact(1'b0, F3_B,  32'h8003_FFFF, 32'h0,         32'h0000_0001, 1'b0, 0);

        xact(1'b1, F3_W,  32'h8000_0020, 32'h1111_2222, 32'h0000_0000, 1'b0, 0);
        xact(1'b0, F3_W,  32'h8000_0010, 32'h0,         32'hCAFE_55EF, 1'b0, 5);
        xact(1'b0, F3_W,  32'h8000_0020, 32'h0,         32'h1111_2222, 1'b0, 0);

        // Reset lands while a load is in ACCESS: it must vanish without a response.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_rwtyp = F3_W;
        req_addr  = 32'h8000_0010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("cancel_in_access", resp_valid, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("cancel_req_ready", req_ready, 32'd1);
        chk("cancel_resp_valid", resp_valid, 32'd0);
        chk("cancel_resp_rdata", resp_rdata, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("no_stale_resp", resp_valid, 32'd0);
        end

        // A store offered during reset is refused and leaves the array alone.
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_rwtyp = F3_W;
        req_addr  = 32'h8000_0010;
        req_wdata = 32'h0BAD_F00D;
        #1;
        chk("rst_store_ready", req_ready, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
        xact(1'b0, F3_W,  32'h8000_0010, 32'h0,         32'hCAFE_55EF, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/emu_ram_hs.md
EMU_RAM_HS -- requirements
Module: emu_ram_hs

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter DEPTH_LOG2, default 16, log2 of the number of 32-bit words.
REQ-003 Parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port req_valid  input  1  request present.
REQ-007 Port req_ready  output  1  block accepts a request this cycle.
REQ-008 Port req_we  input  1  1 = store, 0 = load.
REQ-009 Port req_rwtyp  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 Port req_addr  input  ADDR_WIDTH  byte address.
REQ-011 Port req_wdata  input  32  store data, right-aligned.
REQ-012 Port resp_valid  output  1  response present.
REQ-013 Port resp_ready  input  1  consumer accepts the response.
REQ-014 Port resp_rdata  output  32  formatted load data; 0 for stores and errors.
REQ-015 Port resp_err  output  1  access faulted; no memory side effect.

Function
REQ-016 The handshake SHALL use valid/ready: a transfer occurs on a rising edge with valid and ready both high; request fields SHALL be sampled only on that edge.
REQ-017 The FSM SHALL have three states: IDLE (req_ready=1), ACCESS, RESP (resp_valid=1).
REQ-018 IDLE SHALL go to ACCESS on request transfer and otherwise remain in IDLE.
REQ-019 ACCESS SHALL last exactly one cycle and then go to RESP.
REQ-020 RESP SHALL hold resp_rdata and resp_err stable until resp_ready is high, then go to IDLE.
REQ-021 Minimum latency SHALL be request edge + 2 cycles to resp_valid, with one transaction outstanding at most.
REQ-022 req_ready SHALL be 1 only in IDLE; no request SHALL be accepted in ACCESS or RESP.
REQ-023 An error SHALL be flagged for any of the following:
- rwtyp 011, 110 or 111;
- store with rwtyp 100 or 101;
- H/HU with addr[0]=1;
- W with addr[1:0]!=0;
- addr-BASE_ADDR >= 4<<DEPTH_LOG2, computed unsigned over ADDR_WIDTH bits, so addresses below the base wrap and fault.
REQ-024 A faulting store SHALL NOT modify the array; a faulting load SHALL return resp_rdata=0.
REQ-025 A store SHALL write on the accepting edge, using byte enables 0001<<a, 0011<<a or 1111 with a=addr[1:0], and data shifted left by 8*a; unenabled bytes SHALL be preserved.
REQ-026 A load SHALL issue the array read on the accepting edge; in ACCESS, the word SHALL be shifted right by 8*a, then truncated to 8/16/32 bits.
REQ-027 Data SHALL be sign-extended for B/H and zero-extended for BU/HU.
REQ-028 The formatted result SHALL be registered into resp_rdata at the ACCESS→RESP edge.
REQ-029 A load accepted in the cycle after a store to the same word SHALL return the post-store data, because the array is write-first on consecutive edges.

Reset
REQ-030 When rst=1 at an edge, the FSM SHALL go to IDLE, and resp_valid, resp_err and resp_rdata SHALL be 0.
REQ-031 Reset SHALL NOT clear array contents; it SHALL cancel any in-flight load without a response.
REQ-032 A store accepted on the same edge that rst is sampled high SHALL NOT be performed.
REQ-033 req_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst falls.

Structure
REQ-034 Package emu_ram_pkg SHALL hold the funct3 encoding constants, the FSM state enum and the byte-enable/extension helper functions.
REQ-035 Sub-module emu_ram_array SHALL implement a 2**DEPTH_LOG2 x 32 synchronous RAM with 4-bit byte enables and a registered read port.
REQ-036 emu_ram_array SHALL keep the Verilator DPI pointer export behind `__VERILATOR__`.
REQ-037 All error, format and FSM logic SHALL reside in emu_ram_hs.

Verification
REQ-038 SW 0x8000_0010 ← 0xDEADBEEF, then LW 0x8000_0010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 2 cycles after acceptance.
REQ-039 After REQ-038: LB 0x8000_0013 -> 0xFFFFFFDE; LBU 0x8000_0013 -> 0x000000DE; LH 0x8000_0012 -> 0xFFFFDEAD; LHU 0x8000_0010 -> 0x0000BEEF.
REQ-040 SB 0x8000_0011 ← 0x55, then LW 0x8000_0010 -> 0xDEAD55EF.
REQ-041 LW 0x8000_0012, SH 0x8000_0011, LW 0x7FFF_FFFC and rwtyp 011 each -> resp_err=1, rdata=0; then LW 0x8000_0010 -> word unchanged.
REQ-042 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stable, req_ready=0, and a new req_valid is not accepted until the cycle after resp_ready=1.
REQ-043 Assert rst during ACCESS of a load -> next cycle: IDLE, resp_valid=0, req_ready=1, and no stale response appears.
